// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: PC owner, 1-cycle imem fetch, DEPTH-entry queue, decoded head fields.
// Define IFQ_STATS_EN to add saturating stat_flush / stat_stall counters.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          IMEM_AW  = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fetch_en,
  input  logic                   redir_valid,
  input  logic [31:0]            redir_pc,
  output logic                   imem_en,
  output logic [IMEM_AW-1:0]     imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic [5:0]             out_op,
  output logic [5:0]             out_funct,
  output logic [4:0]             out_rs,
  output logic [4:0]             out_rt,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_shamt,
  output logic [15:0]            out_imm,
  output logic [31:0]            out_imm_sext,
  output logic [25:0]            out_addr,
  output logic [31:0]            out_jtarget,
`ifdef IFQ_STATS_EN
  output logic [15:0]            stat_flush,
  output logic [15:0]            stat_stall,
`endif
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ipc_q, ipc_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] sel;
  logic [PW:0]   level_q, level_d;
  logic [PW+1:0] occ;
  logic          issue, push, pop;
  logic [31:0]   redir_tgt, pc_plus4;
  logic [31:0]   ent_pc  [DEPTH];
  logic [31:0]   ent_ins [DEPTH];

  // Occupancy counts the word already in flight so the queue can never overflow.
  assign occ       = {1'b0, level_q} + {{(PW+1){1'b0}}, inflight_q};
  assign issue     = reset_n & fetch_en & ~redir_valid
                   & (occ < (PW+2)'(DEPTH));
  assign push      = inflight_q & ~redir_valid;
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready & ~redir_valid;
  assign redir_tgt = redir_pc & ~32'h3;

  assign imem_en   = issue;
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign level     = level_q;

  // Next-state: redirect has priority and flushes queue and in-flight word.
  always_comb begin
    pc_d       = pc_q;
    ipc_d      = ipc_q;
    inflight_d = issue;
    head_d     = head_q;
    tail_d     = tail_q;
    level_d    = level_q;
    if (redir_valid) begin
      pc_d       = redir_tgt;
      inflight_d = 1'b0;
      tail_d     = head_q;
      level_d    = '0;
    end else begin
      if (issue) begin
        pc_d  = pc_q + 32'd4;
        ipc_d = pc_q;
      end
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      if (push && !pop)
        level_d = level_q + (PW+1)'(1);
      else if (pop && !push)
        level_d = level_q - (PW+1)'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      ipc_q      <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      level_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      ipc_q      <= ipc_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      level_q    <= level_d;
    end
  end

  // Queue storage: returning word written at tail with its issuing PC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc[i]  <= '0;
        ent_ins[i] <= '0;
      end
    end else if (push) begin
      ent_pc[tail_q]  <= ipc_q;
      ent_ins[tail_q] <= imem_rdata;
    end
  end

  // When empty, show the slot just behind head so fields hold the last head.
  assign sel = (level_q == '0) ? head_q - PW'(1) : head_q;

  assign out_pc       = ent_pc[sel];
  assign out_instr    = ent_ins[sel];
  assign out_op       = out_instr[31:26];
  assign out_funct    = out_instr[5:0];
  assign out_rs       = out_instr[25:21];
  assign out_rt       = out_instr[20:16];
  assign out_rd       = out_instr[15:11];
  assign out_shamt    = out_instr[10:6];
  assign out_imm      = out_instr[15:0];
  assign out_imm_sext = {{16{out_instr[15]}}, out_instr[15:0]};
  assign out_addr     = out_instr[25:0];
  assign pc_plus4     = out_pc + 32'd4;
  assign out_jtarget  = {pc_plus4[31:28], out_instr[25:0], 2'b00};

`ifdef IFQ_STATS_EN
  logic [15:0] stat_flush_q;
  logic [15:0] stat_stall_q;
  logic        stall;

  assign stall      = fetch_en & ~redir_valid & ~issue;
  assign stat_flush = stat_flush_q;
  assign stat_stall = stat_stall_q;

  // Saturating redirect and fetch-stall counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_flush_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (redir_valid && stat_flush_q != 16'hFFFF)
        stat_flush_q <= stat_flush_q + 16'd1;
      if (stall && stat_stall_q != 16'hFFFF)
        stat_stall_q <= stat_stall_q + 16'd1;
    end
  end
`endif

endmodule
